// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between unsigned_multiplier, product_accumulator and its consumer.
// ACC_LAST_EN adds in_last (early group close) and out_len (beats in the closed group).
interface product_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);
  localparam int ACC_W = 2 * WIDTH + $clog2(COUNT);
  localparam int LEN_W = $clog2(COUNT) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   in_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_sum;
`ifdef ACC_LAST_EN
  logic                 in_last;
  logic [LEN_W-1:0]     out_len;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_len
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_len
  );
`else
  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum
  );
`endif
endinterface

// File: rtl/product_accumulator.sv
// Sums each group of COUNT unsigned products and hands the sum downstream over valid/ready.
// Optional macro ACC_LAST_EN: in_last closes a group early and out_len reports its beat count.
module product_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  product_accumulator_if.slave bus
);
  localparam int ACC_W = 2 * WIDTH + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT);
  localparam int LEN_W = CNT_W + 1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             in_ready_r;
  logic             in_ready_nxt_s;
  logic             out_valid_r;
  logic             out_valid_nxt_s;
  logic [ACC_W-1:0] out_sum_r;
  logic [ACC_W-1:0] out_sum_nxt_s;
  logic             accept_s;
  logic             close_s;
  logic [ACC_W-1:0] sum_s;
`ifdef ACC_LAST_EN
  logic [LEN_W-1:0] out_len_r;
  logic [LEN_W-1:0] out_len_nxt_s;
`endif

  assign accept_s = bus.in_valid && in_ready_r;
  assign sum_s    = acc_r + ACC_W'(bus.in_product);
`ifdef ACC_LAST_EN
  assign close_s  = (cnt_r == CNT_W'(COUNT - 1)) || bus.in_last;
`else
  assign close_s  = (cnt_r == CNT_W'(COUNT - 1));
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath update; clear outranks everything except rst_n
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    out_valid_nxt_s = out_valid_r;
    out_sum_nxt_s   = out_sum_r;
`ifdef ACC_LAST_EN
    out_len_nxt_s   = out_len_r;
`endif
    if (clear) begin
      state_nxt_s     = ACCUM;
      acc_nxt_s       = '0;
      cnt_nxt_s       = '0;
      out_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s && close_s) begin
            out_sum_nxt_s   = sum_s;
            out_valid_nxt_s = 1'b1;
            acc_nxt_s       = '0;
            cnt_nxt_s       = '0;
            state_nxt_s     = HOLD;
`ifdef ACC_LAST_EN
            out_len_nxt_s   = LEN_W'(cnt_r) + LEN_W'(1);
`endif
          end else if (accept_s) begin
            acc_nxt_s = sum_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            acc_nxt_s = acc_r;
          end
        end
        HOLD: begin
          // in_ready is low here, so upstream data is simply not looked at
          if (bus.out_ready) begin
            out_valid_nxt_s = 1'b0;
            state_nxt_s     = ACCUM;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s     = ACCUM;
          acc_nxt_s       = '0;
          cnt_nxt_s       = '0;
          out_valid_nxt_s = 1'b0;
        end
      endcase
    end
    in_ready_nxt_s = (state_nxt_s == ACCUM);
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
`ifdef ACC_LAST_EN
      out_len_r   <= '0;
`endif
    end else begin
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_sum_r   <= out_sum_nxt_s;
`ifdef ACC_LAST_EN
      out_len_r   <= out_len_nxt_s;
`endif
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
`ifdef ACC_LAST_EN
  assign bus.out_len   = out_len_r;
`endif
endmodule
